// File: rtl/picomips_pkg.sv
// Shared opcodes, FSM encodings, flag positions and ALU functions for the
// multi-cycle picoMIPS core.
package picomips_pkg;

   localparam logic [5:0] OP_NOP    = 6'd0;
   localparam logic [5:0] OP_ADD    = 6'd1;
   localparam logic [5:0] OP_SUB    = 6'd2;
   localparam logic [5:0] OP_AND    = 6'd3;
   localparam logic [5:0] OP_OR     = 6'd4;
   localparam logic [5:0] OP_ADDI   = 6'd5;
   localparam logic [5:0] OP_SUBI   = 6'd6;
   localparam logic [5:0] OP_BEQ    = 6'd7;
   localparam logic [5:0] OP_BNE    = 6'd8;
   localparam logic [5:0] OP_J      = 6'd9;
   localparam logic [5:0] OP_WAITSW = 6'd10;
   localparam logic [5:0] OP_OUT    = 6'd11;
   localparam logic [5:0] OP_HALT   = 6'd12;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_EXEC  = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_HALT  = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE  = S_IDLE,
      ST_FETCH = S_FETCH,
      ST_EXEC  = S_EXEC,
      ST_WAIT  = S_WAIT,
      ST_HALT  = S_HALT
   } state_t;

   // Flag vector is packed {C,V,N,Z}.
   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_V = 2;
   localparam int FLAG_C = 3;

   typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_func_t;

   typedef struct packed {
      state_t     state;
      logic [3:0] flags;
   } core_dbg_t;

endpackage

// File: rtl/picomips_mc_alu.sv
// Combinational ALU: add/sub/and/or with {C,V,N,Z} flags, result wraps mod 2**n.
module picomips_mc_alu
   import picomips_pkg::*;
#(
   parameter int n = 8
) (
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   input  alu_func_t    func,
   output logic [n-1:0] result,
   output logic [3:0]   flags
);

   logic [n:0] sum;
   logic       c;
   logic       v;

   // For SUB the extra bit of the (n+1)-bit difference is the unsigned borrow.
   always_comb begin
      sum    = '0;
      result = '0;
      c      = 1'b0;
      v      = 1'b0;
      case (func)
         ALU_ADD: begin
            sum    = {1'b0, a} + {1'b0, b};
            result = sum[n-1:0];
            c      = sum[n];
            v      = (a[n-1] == b[n-1]) && (result[n-1] != a[n-1]);
         end
         ALU_SUB: begin
            sum    = {1'b0, a} - {1'b0, b};
            result = sum[n-1:0];
            c      = sum[n];
            v      = (a[n-1] != b[n-1]) && (result[n-1] != a[n-1]);
         end
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         default: result = '0;
      endcase
      flags         = '0;
      flags[FLAG_C] = c;
      flags[FLAG_V] = v;
      flags[FLAG_N] = result[n-1];
      flags[FLAG_Z] = (result == '0);
   end

endmodule

// File: rtl/picomips_mc_core.sv
// Multi-cycle picoMIPS core: req/ack instruction fetch, register file,
// compare-and-branch, switch wait, registered LED port and HALT.
module picomips_mc_core
   import picomips_pkg::*;
#(
   parameter  int n     = 8,
   parameter  int A     = 5,
   parameter  int Psize = 6,
   localparam int Isize = 6 + 2 * A + n
) (
   input  logic             clk,
   input  logic             reset,
   output logic             imem_req,
   output logic [Psize-1:0] imem_addr,
   input  logic             imem_ack,
   input  logic [Isize-1:0] imem_rdata,
   input  logic [n-1:0]     sw,
   input  logic             sw_strobe,
   output logic [n-1:0]     led,
   output logic             led_valid,
   output logic             halted,
   output core_dbg_t        dbg
);

   state_t           state;
   logic [Psize-1:0] pc;
   logic [Isize-1:0] ir;
   logic [n-1:0]     rf [2**A];
   logic [3:0]       flags;

   logic [5:0]       op;
   logic [A-1:0]     rd;
   logic [A-1:0]     rs;
   logic [n-1:0]     imm;
   logic [n-1:0]     rd_val;
   logic [n-1:0]     rs_val;

   logic             alu_en;
   alu_func_t        alu_func;
   logic [n-1:0]     alu_b;
   logic [n-1:0]     alu_result;
   logic [3:0]       alu_flags;

   logic [Psize-1:0] pc_inc;
   logic [n-1:0]     br_sum;
   logic [Psize-1:0] next_pc;

   assign op     = ir[Isize-1 -: 6];
   assign rd     = ir[n+2*A-1 : n+A];
   assign rs     = ir[n+A-1 : n];
   assign imm    = ir[n-1:0];
   assign rd_val = (rd == '0) ? '0 : rf[rd];
   assign rs_val = (rs == '0) ? '0 : rf[rs];

   always_comb begin
      alu_en   = 1'b0;
      alu_func = ALU_ADD;
      alu_b    = rs_val;
      case (op)
         OP_ADD:  alu_en = 1'b1;
         OP_SUB:  begin alu_en = 1'b1; alu_func = ALU_SUB; end
         OP_AND:  begin alu_en = 1'b1; alu_func = ALU_AND; end
         OP_OR:   begin alu_en = 1'b1; alu_func = ALU_OR;  end
         OP_ADDI: begin alu_en = 1'b1; alu_b = imm; end
         OP_SUBI: begin alu_en = 1'b1; alu_func = ALU_SUB; alu_b = imm; end
         default: alu_en = 1'b0;
      endcase
   end

   picomips_mc_alu #(.n(n)) u_alu (
      .a      (rd_val),
      .b      (alu_b),
      .func   (alu_func),
      .result (alu_result),
      .flags  (alu_flags)
   );

   // Branch offset summed at n bits then truncated; Psize <= n keeps this mod 2**Psize.
   assign pc_inc = pc + Psize'(1);
   assign br_sum = n'(pc) + n'(1) + imm;

   always_comb begin
      next_pc = pc_inc;
      case (op)
         OP_J:    next_pc = imm[Psize-1:0];
         OP_BEQ:  if (flags[FLAG_Z])  next_pc = br_sum[Psize-1:0];
         OP_BNE:  if (!flags[FLAG_Z]) next_pc = br_sum[Psize-1:0];
         default: next_pc = pc_inc;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         pc        <= '0;
         ir        <= '0;
         flags     <= '0;
         led       <= '0;
         led_valid <= 1'b0;
         for (int i = 0; i < 2**A; i++) rf[i] <= '0;
      end else begin
         led_valid <= 1'b0;
         case (state)
            ST_IDLE:  state <= ST_FETCH;
            ST_FETCH: if (imem_ack) begin
               ir    <= imem_rdata;
               state <= ST_EXEC;
            end
            ST_EXEC: begin
               pc <= next_pc;
               if (alu_en) begin
                  flags <= alu_flags;
                  if (rd != '0) rf[rd] <= alu_result;
               end
               if (op == OP_OUT) begin
                  led       <= rd_val;
                  led_valid <= 1'b1;
               end
               if (op == OP_WAITSW)    state <= ST_WAIT;
               else if (op == OP_HALT) state <= ST_HALT;
               else                    state <= ST_FETCH;
            end
            ST_WAIT: if (sw_strobe) begin
               rf[1] <= sw;
               state <= ST_FETCH;
            end
            ST_HALT:  state <= ST_HALT;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   assign imem_req  = (state == ST_FETCH);
   assign imem_addr = pc;
   assign halted    = (state == ST_HALT);
   assign dbg       = '{state: state, flags: flags};

endmodule

// File: doc/picomips_mc_core.md
Name: picomips_mc_core

Overview:
- Parametrised multi-cycle successor to the single-cycle picoMIPS top.
- Contains a generic-width datapath, a configurable register-file depth and an external instruction memory with a variable-latency req/ack handshake.
- Adds compare-and-branch, a switch-wait handshake, a registered LED output port and HALT.
- Sits as the CPU core between an instruction ROM/RAM wrapper and the board switch/LED pins.

Parameters:
- n, 8: data width (bits).
- A, 5: register address width; register file depth 2**A.
- Psize, 6: program counter width; requires Psize <= n.
- Isize, 6+2*A+n: instruction width (24 at defaults). Derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  Psize  fetch address, equal to PC.
- imem_ack  in  1  fetch complete; imem_rdata is valid in this cycle.
- imem_rdata  in  Isize  instruction word.
- sw  in  n  switch data.
- sw_strobe  in  1  one-cycle pulse: sw is valid.
- led  out  n  registered output port.
- led_valid  out  1  one-cycle pulse when led is updated.
- halted  out  1  high once HALT has executed.

Behaviour:
- Instruction fields:
  - op = I[Isize-1:Isize-6]
  - rd = I[n+2A-1:n+A] (destination and source a)
  - rs = I[n+A-1:n] (source b)
  - imm = I[n-1:0]
- Register file:
  - r0 always reads 0; writes to it are discarded.
  - r1 is the switch register. It is read/write and is also loaded by WAITSW.
- Opcodes, all others treated as NOP:
  - NOP.
  - ADD/SUB/AND/OR: rd = rd op rs.
  - ADDI/SUBI: rd = rd op imm.
  - BEQ/BNE: branch if Z==1 / Z==0.
  - J: absolute branch.
  - WAITSW.
  - OUT: led = rd.
  - HALT.
- Flags {C,V,N,Z}:
  - Updated only by ADD/SUB/AND/OR/ADDI/SUBI.
  - C = carry-out on ADD; borrow (a<b unsigned) on SUB.
  - V = two's-complement overflow.
  - AND/OR clear C and V.
  - Result wraps modulo 2**n.
- FSM states: IDLE, FETCH, EXEC, WAIT, HALT.
  - IDLE: entered on reset; moves to FETCH on the next clock.
  - FETCH: imem_req=1 and imem_addr=PC held stable until imem_ack. On the ack edge, capture imem_rdata into the IR and move to EXEC. An ack arriving outside FETCH is ignored.
  - EXEC: execute the IR in one cycle, then:
    - register write and flag update take effect on the EXEC edge;
    - PC <= next_pc;
    - WAITSW moves to WAIT (PC already advanced);
    - HALT moves to HALT;
    - all other opcodes move to FETCH.
  - WAIT: on sw_strobe, r1 <= sw and move to FETCH. sw_strobe in any other state is ignored.
  - HALT: terminal; halted=1 and imem_req=0. Only reset leaves it.
- next_pc:
  - default: PC+1, wrapping mod 2**Psize.
  - J: imm[Psize-1:0].
  - taken BEQ/BNE: PC+1+sign-extended imm, truncated to Psize (wraps both directions).
  - untaken branch: PC+1.
- Throughput: minimum 2 cycles per instruction (ack in the first FETCH cycle); each ack wait cycle adds 1.
- Outputs:
  - imem_req is combinational from state; 0 in IDLE, EXEC, WAIT and HALT.
  - OUT loads led on the EXEC edge; led_valid is high for exactly the following cycle.
- Reset (asynchronous assert, synchronous-safe release):
  - PC=0, IR=0, all registers=0, flags=0, led=0, led_valid=0, halted=0, state=IDLE.
  - imem_req drops immediately, including mid-fetch.
  - An in-flight ack is dropped and no partial instruction executes.
  - A mid-WAIT reset abandons the wait.

Decomposition:
- picomips_pkg holds:
  - the opcode localparams (6-bit);
  - the state_t enum;
  - flag bit indices;
  - the ALU function enum.
- One sub-module, picomips_mc_alu: combinational, parameter n; inputs a, b and func; outputs result[n] and flags[4].
- Register file and FSM stay in the core.

Test Plan:
- Fetch latency: ADDI r2,5 with ack delayed 3 cycles.
  - imem_addr is held at 0 throughout.
  - r2=5 one cycle after ack.
  - The next request goes to address 1.
- Arithmetic and flags: r2=0xFF, ADDI r2,1.
  - r2=0x00, Z=1, C=1.
  - Then SUBI r2,1 gives r2=0xFF, C=1, N=1.
- Branch wrap: PC=63, BNE taken with imm=0x01 → next fetch at address 1.
  - BEQ with imm=0xFE at PC=0 → next fetch at address 63.
- WAITSW then OUT r1: hold sw=0xA5 with no strobe for 10 cycles → no fetch occurs.
  - Strobe → r1=0xA5.
  - After the OUT instruction's EXEC edge: led=0xA5 and led_valid high for exactly 1 cycle.
- HALT: after HALT, halted=1 and imem_req stays 0 for 20 cycles.
  - Release reset → a fetch at address 0 follows 1 cycle after IDLE.
- Async reset mid-fetch: assert reset while imem_req=1 and pulse ack in the same cycle.
  - All outputs return to 0 immediately.
  - No register write occurs.
  - The first post-reset fetch is at address 0.
